// File: rtl/neopix_pkg.sv
// Shared definitions for the NeoPixel transmitter: state encoding, default
// 50 MHz timing constants and the byte width.
package neopix_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam int unsigned T0H_CYC_DEF  = 20;
  localparam int unsigned T1H_CYC_DEF  = 40;
  localparam int unsigned TBIT_CYC_DEF = 63;
  localparam int unsigned TRST_CYC_DEF = 15000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_HIGH  = ST_HIGH,
    S_LOW   = ST_LOW,
    S_LATCH = ST_LATCH
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neopix_byte_fifo.sv
// Single-clock byte FIFO; head word is visible on dout in the cycle it is popped.
// Writes while full and reads while empty are ignored.
module neopix_byte_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               din,
  input  logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          wr_ok, rd_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign dout  = mem[rd_ptr_q];
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/neopix_tx.sv
// Buffers bytes and serialises them MSB first onto a WS2812 data line.
// Define NEOPIX_DOUT_INV_EN to drive the line inverted for an inverting level shifter.
module neopix_tx
  import neopix_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned T0H_CYC    = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC    = T1H_CYC_DEF,
  parameter int unsigned TBIT_CYC   = TBIT_CYC_DEF,
  parameter int unsigned TRST_CYC   = TRST_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BYTE_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned CNT_W = $clog2(max_u(TBIT_CYC, TRST_CYC));

`ifdef NEOPIX_DOUT_INV_EN
  localparam logic DOUT_INV = 1'b1;
`else
  localparam logic DOUT_INV = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dout_q, busy_q, ovf_q;

  logic               fifo_rd_c;
  logic [BYTE_W-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty;

  neopix_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_valid),
    .din   (in_data),
    .rd_en (fifo_rd_c),
    .dout  (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Counter reload values are "cycles minus one" so the phase ends on zero.
  function automatic logic [CNT_W-1:0] high_load(input logic b);
    return b ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  endfunction

  function automatic logic [CNT_W-1:0] low_load(input logic b);
    return b ? CNT_W'(TBIT_CYC - T1H_CYC - 1) : CNT_W'(TBIT_CYC - T0H_CYC - 1);
  endfunction

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    fifo_rd_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        fifo_rd_c = 1'b1;
        shift_d   = fifo_rdata;
        bit_idx_d = 3'd7;
        cnt_d     = high_load(fifo_rdata[7]);
        state_d   = S_HIGH;
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          cnt_d   = low_load(shift_q[7]);
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_idx_q != 3'd0) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_idx_d = bit_idx_q - 3'd1;
          cnt_d     = high_load(shift_q[6]);
          state_d   = S_HIGH;
        end else if (!fifo_empty) begin
          // Chain straight into the next byte so the bit period stays constant.
          fifo_rd_c = 1'b1;
          shift_d   = fifo_rdata;
          bit_idx_d = 3'd7;
          cnt_d     = high_load(fifo_rdata[7]);
          state_d   = S_HIGH;
        end else begin
          cnt_d   = CNT_W'(TRST_CYC - 1);
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      dout_q    <= DOUT_INV;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      dout_q    <= DOUT_INV ^ (state_d == S_HIGH);
      busy_q    <= (state_d != S_IDLE);
      if (in_valid && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_neopix_tx.sv
// Scoreboard bench for neopix_tx: expected per-bit high/low run lengths are queued by
// the stimulus and compared by a dout monitor. Honours NEOPIX_DOUT_INV_EN.
module tb_neopix_tx;

  localparam int T0 = 20;
  localparam int T1 = 40;
  localparam int TB = 63;
  localparam int TR = 100;

`ifdef NEOPIX_DOUT_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       dout;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  neopix_tx #(
    .FIFO_DEPTH (4),
    .T0H_CYC    (T0),
    .T1H_CYC    (T1),
    .TBIT_CYC   (TB),
    .TRST_CYC   (TR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .dout       (dout),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int high;
    int low;
    int gap;
  } bit_exp_t;

  bit_exp_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Queue the eight expected bits of one byte; gap is checked only on the first bit.
  task automatic push_byte(input logic [7:0] b, input bit last, input int gap);
    bit_exp_t r;
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) begin
      r.high = v[i] ? T1 : T0;
      r.low  = TB - r.high + ((last && i == 0) ? TR : 0);
      r.gap  = (i == 7) ? gap : -1;
      exp_q.push_back(r);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: measures high runs, low runs (until next rise or busy drop) and idle gap.
  int       m_mode = 0;
  int       hcnt, lcnt, gcnt;
  logic     lvl;
  bit_exp_t cur;

  task automatic start_bit(input bit check_gap);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      cur = '{-1, -1, -1};
    end else begin
      cur = exp_q.pop_front();
      if (check_gap && cur.gap >= 0) chk("frame_gap", gcnt, cur.gap);
    end
    m_mode = 1;
    hcnt   = 1;
  endtask

  always @(negedge clk) begin
    lvl = dout ^ INV;
    if (reset || !mon_en) begin
      m_mode = 0;
      gcnt   = 0;
    end else begin
      case (m_mode)
        0: begin
          if (lvl) start_bit(1'b1);
          else     gcnt++;
        end
        1: begin
          if (lvl) hcnt++;
          else begin
            chk("bit_high", hcnt, cur.high);
            m_mode = 2;
            lcnt   = 1;
          end
        end
        default: begin
          if (lvl) begin
            chk("bit_low", lcnt, cur.low);
            start_bit(1'b0);
          end else if (!busy) begin
            chk("bit_low_latch", lcnt, cur.low);
            m_mode = 0;
            gcnt   = 1;
          end else begin
            lcnt++;
          end
        end
      endcase
    end
  end

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && m_mode == 0) done = 1'b1;
    end
    chk("tx_done", int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", int'(dout), int'(INV));
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1: single byte, latency and latch
    push_byte(8'hA5, 1'b1, -1);
    send(8'hA5);
    @(negedge clk);
    chk("lat_dout_k", int'(dout ^ INV), 0);
    chk("lat_level_k", int'(fifo_level), 1);
    @(negedge clk);
    chk("lat_busy_k1", int'(busy), 1);
    chk("lat_dout_k1", int'(dout ^ INV), 0);
    @(negedge clk);
    chk("lat_dout_k2", int'(dout ^ INV), 1);
    wait_done(2000);
    chk("t1_ovf", int'(overflow), 0);

    // 2: three back-to-back bytes form one frame
    push_byte(8'hFF, 1'b0, -1);
    push_byte(8'h00, 1'b0, -1);
    push_byte(8'h80, 1'b1, -1);
    @(posedge clk);
    #1;
    peak = 0;
    fork
      begin
        send(8'hFF);
        send(8'h00);
        send(8'h80);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
      end
    join
    chk("t2_peak_level", peak, 2);
    wait_done(3000);
    chk("t2_ovf", int'(overflow), 0);

    // 3: byte arriving during LATCH starts a new frame after the full latch
    push_byte(8'h01, 1'b1, -1);
    push_byte(8'h01, 1'b1, 2);
    @(posedge clk);
    #1;
    send(8'h01);
    repeat (525) @(posedge clk);
    #1;
    send(8'h01);
    @(negedge clk);
    chk("t3_in_latch_busy", int'(busy), 1);
    chk("t3_in_latch_dout", int'(dout ^ INV), 0);
    wait_done(2000);

    // 4: depth-4 FIFO, six writes -> one dropped
    push_byte(8'h11, 1'b0, -1);
    push_byte(8'h22, 1'b0, -1);
    push_byte(8'h33, 1'b0, -1);
    push_byte(8'h44, 1'b0, -1);
    push_byte(8'h55, 1'b1, -1);
    @(posedge clk);
    #1;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    chk("t4_ovf_before", int'(overflow), 0);
    send(8'h66);
    @(negedge clk);
    chk("t4_level_full", int'(fifo_level), 4);
    chk("t4_ovf_set", int'(overflow), 1);
    wait_done(4000);
    chk("t4_ovf_sticky", int'(overflow), 1);

    // 5: reset during HIGH of bit 3 aborts and flushes
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    send(8'hA5);
    send(8'h3C);
    repeat (257) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_pre_dout", int'(dout ^ INV), 1);
    chk("t5_pre_level", int'(fifo_level), 1);
    @(negedge clk);
    chk("t5_rst_dout", int'(dout), int'(INV));
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_level", int'(fifo_level), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_quiet_busy", int'(busy), 0);
    push_byte(8'h80, 1'b1, -1);
    send(8'h80);
    wait_done(2000);
    chk("t5_ovf", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
